// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
package alu_pkg;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned ALU_OPW = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
  typedef logic [ALU_OPW-1:0] alu_op_t;

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational 2-way round-robin picker: a lone valid always wins, a tie goes
// to the requester that was not granted last.
module alu_rr_grant
  import alu_pkg::*;
(
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic            o_id
);

  always_comb begin
    o_grant = '0;
    o_id    = 1'b0;
    case (i_valid)
      2'b01: begin
        o_grant = 2'b01;
        o_id    = 1'b0;
      end
      2'b10: begin
        o_grant = 2'b10;
        o_id    = 1'b1;
      end
      2'b11: begin
        o_grant = i_last_grant ? 2'b01 : 2'b10;
        o_id    = ~i_last_grant;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant, hold
// operands for ALU_LAT cycles, capture the result and return it tagged by id.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned BITS    = 8,
  parameter int unsigned OPW     = 2,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [OPW-1:0]  i_req0_op,
  input  logic [BITS-1:0] i_req0_argA,
  input  logic [BITS-1:0] i_req0_argB,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [OPW-1:0]  i_req1_op,
  input  logic [BITS-1:0] i_req1_argA,
  input  logic [BITS-1:0] i_req1_argB,
  output logic [OPW-1:0]  o_alu_op,
  output logic [BITS-1:0] o_alu_argA,
  output logic [BITS-1:0] o_alu_argB,
  input  logic [BITS-1:0] i_alu_result,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [BITS-1:0] o_rsp_result,
  output logic            o_busy
);

  localparam int unsigned CNT_W = (ALU_LAT == 0) ? 1 : $clog2(ALU_LAT + 1);

  if (ALU_LAT == 0) begin : g_lat_check
    $error("alu_share_arbiter: ALU_LAT must be >= 1");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic [OPW-1:0]    r_alu_op;
  logic [BITS-1:0]   r_alu_argA;
  logic [BITS-1:0]   r_alu_argB;
  logic              r_rsp_id;
  logic [BITS-1:0]   r_rsp_result;

  logic [NREQ-1:0]   w_grant;
  logic              w_id;
  logic              w_accept;
  logic              w_capture;

  alu_rr_grant u_rr_grant (
    .i_valid      ({i_req1_valid, i_req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_id         (w_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_alu_op     <= '0;
      r_alu_argA   <= '0;
      r_alu_argB   <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt        <= CNT_W'(ALU_LAT - 1);
        r_last_grant <= w_id;
        r_rsp_id     <= w_id;
        r_alu_op     <= w_id ? i_req1_op   : i_req0_op;
        r_alu_argA   <= w_id ? i_req1_argA : i_req0_argA;
        r_alu_argB   <= w_id ? i_req1_argB : i_req0_argB;
      end else if (r_state == EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) r_rsp_result <= i_alu_result;
    end
  end

  // Ready is gated by reset so it reads zero while reset is asserted.
  assign o_req0_ready = (r_state == IDLE) && !i_rst && w_grant[0];
  assign o_req1_ready = (r_state == IDLE) && !i_rst && w_grant[1];
  assign o_alu_op     = r_alu_op;
  assign o_alu_argA   = r_alu_argA;
  assign o_alu_argB   = r_alu_argB;
  assign o_rsp_valid  = (r_state == RESP);
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level
// model; the ALU is modelled as result = argA >>> 1.
module tb_alu_share_arbiter;

  localparam int unsigned BITS    = 8;
  localparam int unsigned OPW     = 2;
  localparam int unsigned ALU_LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [OPW-1:0]  req0_op, req1_op;
  logic [BITS-1:0] req0_argA, req0_argB, req1_argA, req1_argB;
  logic [OPW-1:0]  alu_op;
  logic [BITS-1:0] alu_argA, alu_argB, alu_result;
  logic            rsp_valid, rsp_ready, rsp_id, busy;
  logic [BITS-1:0] rsp_result;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: one outstanding op, stamped with its accept cycle.
  int          m_cyc = 0;
  bit          m_have_op;
  int          m_acc;
  bit          m_id;
  bit          m_last;
  logic [1:0]  m_op;
  logic [7:0]  m_a, m_b;
  int          m_grants[$];

  always #5 clk = ~clk;

  assign alu_result = $signed(alu_argA) >>> 1;

  alu_share_arbiter #(
    .BITS    (BITS),
    .OPW     (OPW),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_op    (req0_op),
    .i_req0_argA  (req0_argA),
    .i_req0_argB  (req0_argB),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_op    (req1_op),
    .i_req1_argA  (req1_argA),
    .i_req1_argB  (req1_argB),
    .o_alu_op     (alu_op),
    .o_alu_argA   (alu_argA),
    .o_alu_argB   (alu_argB),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .o_busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  // Floor of a signed byte divided by two.
  function automatic logic [7:0] half_floor(input logic [7:0] a);
    int x;
    x = int'($signed(a));
    return 8'((x - (x & 1)) / 2);
  endfunction

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic apply_reset();
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst        = 1'b1;
    #1;
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(req1_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_result", 32'(rsp_result), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_alu_argA", 32'(alu_argA), 32'd0);
    check_eq("rst_alu_argB", 32'(alu_argB), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    m_have_op = 1'b0;
    m_last    = 1'b1;
    m_grants.delete();
  endtask

  task automatic drive(input logic v0, input logic [1:0] op0, input logic [7:0] a0,
                       input logic [7:0] b0, input logic v1, input logic [1:0] op1,
                       input logic [7:0] a1, input logic [7:0] b1, input logic rr);
    bit exp_r0, exp_r1, exp_rv, gid;
    @(posedge clk);
    m_cyc++;
    #1;
    req0_valid = v0; req0_op = op0; req0_argA = a0; req0_argB = b0;
    req1_valid = v1; req1_op = op1; req1_argA = a1; req1_argB = b1;
    rsp_ready  = rr;
    #4;
    gid    = (v0 && v1) ? !m_last : !v0;
    exp_r0 = !m_have_op && (v0 || v1) && !gid;
    exp_r1 = !m_have_op && (v0 || v1) && gid;
    exp_rv = m_have_op && (m_cyc >= m_acc + int'(ALU_LAT) + 1);
    check_eq("ready0", 32'(req0_ready), 32'(exp_r0));
    check_eq("ready1", 32'(req1_ready), 32'(exp_r1));
    check_eq("busy", 32'(busy), 32'(m_have_op));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (m_have_op) begin
      check_eq("alu_op", 32'(alu_op), 32'(m_op));
      check_eq("alu_argA", 32'(alu_argA), 32'(m_a));
      check_eq("alu_argB", 32'(alu_argB), 32'(m_b));
    end
    if (exp_rv) begin
      check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
      check_eq("rsp_result", 32'(rsp_result), 32'(half_floor(m_a)));
    end
    if (!m_have_op) begin
      if (v0 || v1) begin
        m_have_op = 1'b1;
        m_acc     = m_cyc;
        m_id      = gid;
        m_last    = gid;
        m_op      = gid ? op1 : op0;
        m_a       = gid ? a1 : a0;
        m_b       = gid ? b1 : b0;
        m_grants.push_back(int'(gid));
      end
    end else if (exp_rv && rr) begin
      m_have_op = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, rr);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_argA = '0; req0_argB = '0;
    req1_valid = 1'b0; req1_op = '0; req1_argA = '0; req1_argB = '0;
    rsp_ready = 1'b0;
    apply_reset();

    // Single op from req0: 0x84 >>> 1 = 0xC2, response three cycles after accept.
    drive(1'b1, 2'd1, 8'h84, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    idle_cycles(4, 1'b1);

    // Both valid after reset: req0 first, then alternating.
    apply_reset();
    for (int i = 0; i < 16; i++)
      drive(1'b1, 2'd2, 8'(8'h20 + i), 8'h01, 1'b1, 2'd3, 8'(8'hA0 + i), 8'h02, 1'b1);
    check_eq("grant_seq_len", 32'(m_grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < m_grants.size(); i++)
      check_eq("grant_seq", 32'(m_grants[i]), 32'(i % 2));

    // Backpressure: rsp_ready low for 5 cycles in RESP with both requesters valid.
    idle_cycles(6, 1'b1);
    drive(1'b1, 2'd0, 8'h7E, 8'h11, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < ALU_LAT + 5; i++)
      drive(1'b1, 2'd0, 8'h55, 8'h11, 1'b1, 2'd1, 8'h66, 8'h22, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b1, 2'd0, 8'h55, 8'h11, 1'b1, 2'd1, 8'h66, 8'h22, 1'b1);

    // Reset during EXEC: op discarded, req0 wins next.
    idle_cycles(6, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 2'd2, 8'h3C, 8'h00, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    apply_reset();
    idle_cycles(3, 1'b1);
    drive(1'b1, 2'd1, 8'h40, 8'h00, 1'b1, 2'd1, 8'h50, 8'h00, 1'b1);
    idle_cycles(4, 1'b1);

    // Operand changes during EXEC must not reach the ALU.
    drive(1'b1, 2'd3, 8'h10, 8'h05, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 8'hFF, 8'hEE, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    idle_cycles(3, 1'b1);

    // Lone req1 for three back-to-back ops.
    for (int i = 0; i < 12; i++)
      drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 2'(i), 8'(8'h80 + 8'(i * 7)), 8'h09, 1'b1);
    idle_cycles(4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      drive(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
